// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C EEPROM responder.
// FSM states, default device address and bus-level bit meanings.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_DEV,
    ST_WORD_ADDR,
    ST_ACK_WORD,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_DATA,
    ST_MACK
  } state_t;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'b1010001;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
    return addr_byte[7:1] == dev_addr;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchroniser plus history flop for SCL and SDA, with
// edge, START and STOP detection on the synchronised values.
module i2c_bus_sync (
  input  logic CLK,
  input  logic RSTn,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] line_raw;
  logic [1:0] line_sync;
  logic [1:0] line_prev;

  assign line_raw = {sda, scl};

  // Idle bus is high, so flops come out of reset high to avoid phantom edges.
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
        prev_reg <= 1'b1;
      end else begin
        meta_reg <= line_raw[gi];
        sync_reg <= meta_reg;
        prev_reg <= sync_reg;
      end
    end

    assign line_sync[gi] = sync_reg;
    assign line_prev[gi] = prev_reg;
  end

  assign scl_rise  =  line_sync[0] & ~line_prev[0];
  assign scl_fall  = ~line_sync[0] &  line_prev[0];
  assign start_det =  line_sync[0] &  line_prev[0] &  line_prev[1] & ~line_sync[1];
  assign stop_det  =  line_sync[0] &  line_prev[0] & ~line_prev[1] &  line_sync[1];
  assign sda_s     =  line_sync[1];

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C responder emulating a 256-byte 24Cxx EEPROM for on-chip loopback tests.
// SDA is open-drain: only ever driven low or released.
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEFAULT_DEV_ADDR,
  parameter int         MIN_PHASE = 4
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       Wr_Sig,
  output logic [7:0] Wr_Addr,
  output logic [7:0] Wr_Data,
  output logic       Busy
);

  // The synchroniser needs a few CLK per SCL phase to see every edge.
  if (MIN_PHASE < 3) begin : g_phase_check
    $error("MIN_PHASE too short for the SCL/SDA synchroniser");
  end

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .scl       (SCL),
    .sda       (SDA),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] shift_reg, shift_next;
  logic [7:0] tx_reg, tx_next;
  logic [7:0] ptr_reg, ptr_next;
  logic       rw_reg, rw_next;
  logic       sda_low_reg, sda_low_next;
  logic       busy_reg, busy_next;
  logic       wr_sig_reg, wr_sig_next;
  logic [7:0] wr_addr_reg, wr_addr_next;
  logic [7:0] wr_data_reg, wr_data_next;
  logic [7:0] rd_data_reg;
  logic [7:0] rx_byte;

  logic [7:0] mem [256];

  assign rx_byte = {shift_reg, sda_s};

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    ptr_next     = ptr_reg;
    rw_next      = rw_reg;
    sda_low_next = sda_low_reg;
    busy_next    = busy_reg;
    wr_sig_next  = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;

    if (start_det) begin
      state_next   = ST_DEV_ADDR;
      bit_cnt_next = '0;
      sda_low_next = 1'b0;
    end else if (stop_det) begin
      state_next   = ST_IDLE;
      sda_low_next = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: ;

        ST_DEV_ADDR: if (scl_rise) begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (addr_match(rx_byte, DEV_ADDR)) begin
              state_next = ST_ACK_DEV;
              busy_next  = 1'b1;
              rw_next    = rx_byte[0];
            end else begin
              state_next = ST_IDLE;
              busy_next  = 1'b0;
            end
          end
        end

        // First fall after the byte starts the ACK, the next one ends it.
        ST_ACK_DEV, ST_ACK_WORD, ST_ACK_WR: if (scl_fall) begin
          if (!sda_low_reg) begin
            sda_low_next = 1'b1;
          end else begin
            sda_low_next = 1'b0;
            if (state_reg != ST_ACK_DEV) begin
              state_next = ST_WR_DATA;
            end else if (rw_reg == RW_READ) begin
              state_next   = ST_RD_DATA;
              tx_next      = rd_data_reg;
              sda_low_next = ~rd_data_reg[7];
            end else begin
              state_next = ST_WORD_ADDR;
            end
          end
        end

        ST_WORD_ADDR: if (scl_rise) begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            ptr_next   = rx_byte;
            state_next = ST_ACK_WORD;
          end
        end

        ST_WR_DATA: if (scl_rise) begin
          shift_next   = rx_byte[6:0];
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            wr_sig_next  = 1'b1;
            wr_addr_next = ptr_reg;
            wr_data_next = rx_byte;
            ptr_next     = ptr_reg + 8'd1;
            state_next   = ST_ACK_WR;
          end
        end

        // bit_cnt counts bits already clocked out, so it selects the next one.
        ST_RD_DATA: begin
          if (scl_fall) begin
            sda_low_next = ~tx_reg[3'd7 - bit_cnt_reg];
          end
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              ptr_next   = ptr_reg + 8'd1;
              state_next = ST_MACK;
            end
          end
        end

        ST_MACK: begin
          if (scl_fall) begin
            sda_low_next = 1'b0;
          end
          if (scl_rise) begin
            if (sda_s == ACK) begin
              state_next   = ST_RD_DATA;
              bit_cnt_next = '0;
              tx_next      = rd_data_reg;
            end else begin
              state_next = ST_IDLE;
              busy_next  = 1'b0;
            end
          end
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= '0;
      ptr_reg     <= '0;
      rw_reg      <= RW_WRITE;
      sda_low_reg <= 1'b0;
      busy_reg    <= 1'b0;
      wr_sig_reg  <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      ptr_reg     <= ptr_next;
      rw_reg      <= rw_next;
      sda_low_reg <= sda_low_next;
      busy_reg    <= busy_next;
      wr_sig_reg  <= wr_sig_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_sig_next) begin
      mem[ptr_reg] <= rx_byte;
    end
    rd_data_reg <= mem[ptr_reg];
  end

  assign SDA     = sda_low_reg ? 1'b0 : 1'bz;
  assign Wr_Sig  = wr_sig_reg;
  assign Wr_Addr = wr_addr_reg;
  assign Wr_Data = wr_data_reg;
  assign Busy    = busy_reg;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bit-banged I2C master driving the EEPROM responder, checked against a
// byte-array EEPROM model with an auto-incrementing 8-bit pointer.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;

  logic       CLK  = 1'b0;
  logic       RSTn = 1'b0;
  logic       scl  = 1'b1;
  logic       m_low = 1'b0;
  wire        SDA;
  logic       Wr_Sig;
  logic [7:0] Wr_Addr, Wr_Data;
  logic       Busy;

  pullup (SDA);
  assign SDA = m_low ? 1'b0 : 1'bz;

  i2c_eeprom_slave dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .SCL     (scl),
    .SDA     (SDA),
    .Wr_Sig  (Wr_Sig),
    .Wr_Addr (Wr_Addr),
    .Wr_Data (Wr_Data),
    .Busy    (Busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  model_mem [256];
  bit          model_valid [256];
  logic [7:0]  model_ptr = 8'h00;
  logic [7:0]  wbuf [16];
  logic [15:0] exp_q [$];
  logic [15:0] wr_q [$];
  bit          busy_seen = 1'b0;

  always @(negedge CLK) begin
    if (Wr_Sig === 1'b1) wr_q.push_back({Wr_Addr, Wr_Data});
    if (Busy === 1'b1) busy_seen = 1'b1;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One SCL period: data set mid-low, sampled mid-high.
  task automatic send_bit(input logic b, output logic s);
    m_low = ~b;
    clk_wait(4);
    scl = 1'b1;
    clk_wait(4);
    s = SDA;
    clk_wait(4);
    scl = 1'b0;
    clk_wait(4);
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      m_low = 1'b0;
      clk_wait(4);
      scl = 1'b1;
      clk_wait(8);
    end
    m_low = 1'b1;
    clk_wait(8);
    scl = 1'b0;
    clk_wait(4);
  endtask

  task automatic i2c_stop(input bit timed);
    m_low = 1'b1;
    clk_wait(4);
    scl = 1'b1;
    clk_wait(8);
    m_low = 1'b0;
    if (timed) begin
      clk_wait(2);
      n_cmp++;
      if (Busy !== 1'b1) begin
        n_mis++;
        $display("FAIL busy_2clk_after_stop: got %b required 1", Busy);
      end
      clk_wait(1);
      n_cmp++;
      if (Busy !== 1'b0) begin
        n_mis++;
        $display("FAIL busy_3clk_after_stop: got %b required 0", Busy);
      end
      clk_wait(5);
    end else begin
      clk_wait(8);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mack, output logic s9);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(mack, s9);
  endtask

  task automatic do_write(input logic [7:0] addr, input int len, input bit timed);
    logic a;
    logic [15:0] got;
    wr_q.delete();
    exp_q.delete();
    i2c_start();
    write_byte(8'hA2, a);
    n_cmp++;
    if (a !== 1'b0) begin n_mis++; $display("FAIL wr_dev_ack: got %b required 0", a); end
    n_cmp++;
    if (Busy !== 1'b1) begin n_mis++; $display("FAIL busy_in_txn: got %b required 1", Busy); end
    write_byte(addr, a);
    n_cmp++;
    if (a !== 1'b0) begin n_mis++; $display("FAIL word_ack: got %b required 0", a); end
    model_ptr = addr;
    for (int k = 0; k < len; k++) begin
      write_byte(wbuf[k], a);
      n_cmp++;
      if (a !== 1'b0) begin n_mis++; $display("FAIL data_ack: got %b required 0", a); end
      model_mem[model_ptr]   = wbuf[k];
      model_valid[model_ptr] = 1'b1;
      exp_q.push_back({model_ptr, wbuf[k]});
      model_ptr++;
    end
    i2c_stop(timed);
    n_cmp++;
    if (wr_q.size() != exp_q.size()) begin
      n_mis++;
      $display("FAIL wr_sig_count: got %0d required %0d", wr_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      got = wr_q.pop_front();
      n_cmp++;
      if (got !== exp_q[0]) begin
        n_mis++;
        $display("FAIL wr_strobe: got addr=%h data=%h required addr=%h data=%h",
                 got[15:8], got[7:0], exp_q[0][15:8], exp_q[0][7:0]);
      end
      void'(exp_q.pop_front());
    end
    $display("txn write addr=%h len=%0d", addr, len);
  endtask

  task automatic do_read(input bit set_addr, input logic [7:0] addr, input int len);
    logic a, s9;
    logic [7:0] b;
    logic [7:0] start_ptr;
    i2c_start();
    if (set_addr) begin
      write_byte(8'hA2, a);
      n_cmp++;
      if (a !== 1'b0) begin n_mis++; $display("FAIL rd_setup_ack: got %b required 0", a); end
      write_byte(addr, a);
      n_cmp++;
      if (a !== 1'b0) begin n_mis++; $display("FAIL rd_word_ack: got %b required 0", a); end
      model_ptr = addr;
      i2c_start();
    end
    start_ptr = model_ptr;
    write_byte(8'hA3, a);
    n_cmp++;
    if (a !== 1'b0) begin n_mis++; $display("FAIL rd_dev_ack: got %b required 0", a); end
    for (int k = 0; k < len; k++) begin
      read_byte(b, (k == len - 1), s9);
      if (model_valid[model_ptr]) begin
        n_cmp++;
        if (b !== model_mem[model_ptr]) begin
          n_mis++;
          $display("FAIL rd_data[%h]: got %h required %h", model_ptr, b, model_mem[model_ptr]);
        end
      end
      if (k == len - 1) begin
        n_cmp++;
        if (s9 !== 1'b1) begin n_mis++; $display("FAIL nack_released: got %b required 1", s9); end
      end
      model_ptr++;
    end
    i2c_stop(1'b0);
    n_cmp++;
    if (Busy !== 1'b0) begin n_mis++; $display("FAIL busy_after_read: got %b required 0", Busy); end
    $display("txn read %s addr=%h len=%0d", set_addr ? "random" : "current", start_ptr, len);
  endtask

  task automatic test_reset();
    clk_wait(5);
    n_cmp++;
    if (SDA !== 1'b1 || Busy !== 1'b0 || Wr_Sig !== 1'b0 || Wr_Addr !== 8'h00 || Wr_Data !== 8'h00) begin
      n_mis++;
      $display("FAIL reset_state: got sda=%b busy=%b sig=%b addr=%h data=%h required 1 0 0 00 00",
               SDA, Busy, Wr_Sig, Wr_Addr, Wr_Data);
    end
    RSTn = 1'b1;
    clk_wait(5);
    $display("txn reset");
  endtask

  task automatic test_byte_write();
    wbuf[0] = 8'h5A;
    do_write(8'h10, 1, 1'b1);
    n_cmp++;
    if (Wr_Addr !== 8'h10 || Wr_Data !== 8'h5A) begin
      n_mis++;
      $display("FAIL wr_hold: got %h/%h required 10/5a", Wr_Addr, Wr_Data);
    end
  endtask

  task automatic test_random_read();
    do_read(1'b1, 8'h10, 1);
  endtask

  task automatic test_addr_mismatch();
    logic a;
    wr_q.delete();
    busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hA0, a);
    n_cmp++;
    if (a !== 1'b1) begin n_mis++; $display("FAIL mismatch_no_ack: got %b required 1", a); end
    write_byte(8'h10, a);
    n_cmp++;
    if (a !== 1'b1) begin n_mis++; $display("FAIL mismatch_word_no_ack: got %b required 1", a); end
    write_byte(8'h77, a);
    i2c_stop(1'b0);
    n_cmp++;
    if (wr_q.size() != 0 || busy_seen) begin
      n_mis++;
      $display("FAIL mismatch_quiet: got writes=%0d busy_seen=%b required 0 0", wr_q.size(), busy_seen);
    end
    $display("txn mismatch dev=a0");
    wbuf[0] = 8'($urandom);
    do_write(8'($urandom), 1, 1'b0);
  endtask

  task automatic test_seq_wrap();
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wbuf[2] = 8'h33;
    do_write(8'hFE, 3, 1'b0);
    do_read(1'b1, 8'hFE, 3);
  endtask

  task automatic test_abort();
    logic a, s;
    logic [7:0] d;
    wr_q.delete();
    d = 8'($urandom);
    i2c_start();
    write_byte(8'hA2, a);
    write_byte(8'hFF, a);
    model_ptr = 8'hFF;
    for (int i = 7; i >= 4; i--) send_bit(d[i], s);
    i2c_stop(1'b0);
    n_cmp++;
    if (wr_q.size() != 0 || Busy !== 1'b0 || SDA !== 1'b1) begin
      n_mis++;
      $display("FAIL abort: got writes=%0d busy=%b sda=%b required 0 0 1", wr_q.size(), Busy, SDA);
    end
    $display("txn abort data=%h after 4 bits", d);
    do_read(1'b0, 8'h00, 2);
  endtask

  task automatic test_random();
    logic [7:0] addr;
    int len;
    for (int it = 0; it < 6; it++) begin
      addr = 8'($urandom);
      len  = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) wbuf[k] = 8'($urandom);
      do_write(addr, len, 1'b0);
      do_read(1'b1, addr, len);
      if (it[0]) do_read(1'b0, 8'h00, 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] addr;
    addr = 8'($urandom);
    for (int k = 0; k < 3; k++) wbuf[k] = 8'($urandom);
    do_write(addr, 3, 1'b0);
    do_read(1'b1, addr, 1);
    do_read(1'b0, 8'h00, 2);
  endtask

  task automatic test_reset_mid_ack();
    logic a, s;
    logic [7:0] dev;
    dev = 8'hA2;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(dev[i], s);
    m_low = 1'b0;
    clk_wait(4);
    scl = 1'b1;
    clk_wait(2);
    n_cmp++;
    if (SDA !== 1'b0) begin n_mis++; $display("FAIL ack_driven: got %b required 0", SDA); end
    #1;
    RSTn = 1'b0;
    #1;
    n_cmp++;
    if (SDA !== 1'b1 || Busy !== 1'b0 || Wr_Sig !== 1'b0 || Wr_Addr !== 8'h00 || Wr_Data !== 8'h00) begin
      n_mis++;
      $display("FAIL reset_mid_ack: got sda=%b busy=%b sig=%b addr=%h data=%h required 1 0 0 00 00",
               SDA, Busy, Wr_Sig, Wr_Addr, Wr_Data);
    end
    clk_wait(2);
    scl = 1'b0;
    clk_wait(4);
    scl = 1'b1;
    clk_wait(4);
    RSTn = 1'b1;
    clk_wait(4);
    model_ptr = 8'h00;
    $display("txn reset during ack");
    do_read(1'b0, 8'h00, 1);
    write_byte(8'h00, a);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_valid[i] = 1'b0;
    test_reset();
    test_byte_write();
    test_random_read();
    test_addr_mismatch();
    test_seq_wrap();
    test_abort();
    test_random();
    test_back_to_back();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
